// File: rtl/ttl_74193_sync_if.sv
// ttl_74193_sync_if: control, data and cascade signals of one 74193 counter stage
interface ttl_74193_sync_if #(parameter int WIDTH = 4);
    logic CLR;
    logic LOAD_n;
    logic [WIDTH-1:0] D;
    logic UP;
    logic DOWN;
    logic [WIDTH-1:0] Q;
    logic CO_n;
    logic BO_n;
    modport master (output CLR, LOAD_n, D, UP, DOWN, input Q, CO_n, BO_n);
    modport slave (input CLR, LOAD_n, D, UP, DOWN, output Q, CO_n, BO_n);
endinterface

// File: rtl/ttl_74193_sync.sv
// ttl_74193_sync: single-clock 74193 up/down counter with edge-detected count pulses
module ttl_74193_sync #(parameter int WIDTH = 4) (
    input logic clock,
    input logic reset,
    ttl_74193_sync_if.slave bus
);
    logic [WIDTH-1:0] q, nextQ;
    logic upQ, dnQ, upEdge, dnEdge;
    assign upEdge = bus.UP & ~upQ;
    assign dnEdge = bus.DOWN & ~dnQ;
    // a count needs the other pulse input idle high, as in the TTL part
    always_comb begin
        nextQ = bus.CLR ? '0 :
                !bus.LOAD_n ? bus.D :
                (upEdge & ~dnEdge & bus.DOWN) ? q + 1'b1 :
                (dnEdge & ~upEdge & bus.UP) ? q - 1'b1 : q;
    end
    // samples start high so a pulse input held high through reset is not an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
            upQ <= 1'b1;
            dnQ <= 1'b1;
        end else begin
            q <= nextQ;
            upQ <= bus.UP;
            dnQ <= bus.DOWN;
        end
    end
    assign bus.Q = q;
    assign bus.CO_n = ~((&q) & ~upQ);
    assign bus.BO_n = ~((q == '0) & ~dnQ);
endmodule

// File: tb/tb_ttl_74193_sync.sv
// tb_ttl_74193_sync: table-driven checks of one counter plus a two-stage cascade
module tb_ttl_74193_sync;
    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;

    ttl_74193_sync_if #(.WIDTH(4)) bus ();
    ttl_74193_sync_if #(.WIDTH(4)) loBus ();
    ttl_74193_sync_if #(.WIDTH(4)) hiBus ();
    ttl_74193_sync #(.WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    ttl_74193_sync #(.WIDTH(4)) lo (.clock(clock), .reset(reset), .bus(loBus));
    ttl_74193_sync #(.WIDTH(4)) hi (.clock(clock), .reset(reset), .bus(hiBus));
    assign hiBus.UP = loBus.CO_n;
    assign hiBus.DOWN = loBus.BO_n;

    typedef struct {
        logic clr;
        logic loadN;
        logic [3:0] d;
        logic up;
        logic down;
        logic [3:0] q;
        logic coN;
        logic boN;
    } vec_t;
    vec_t vecs [34];

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkOut(input string name, input logic [3:0] q, input logic coN, input logic boN);
        chk({name, ".Q"}, bus.Q, q);
        chk({name, ".CO_n"}, {3'b0, bus.CO_n}, {3'b0, coN});
        chk({name, ".BO_n"}, {3'b0, bus.BO_n}, {3'b0, boN});
    endtask

    task automatic loPulse();
        loBus.UP = 1'b0;
        tick();
        loBus.UP = 1'b1;
        tick();
    endtask

    initial begin
        // columns: CLR, LOAD_n, D, UP, DOWN -> Q, CO_n, BO_n after the edge
        vecs[0]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'd14, 1'b1, 1'b1, 4'd14, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd14, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd15, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd15, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 4'd1,  1'b1, 1'b1, 4'd1,  1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 4'd1,  1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd15, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd15, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'd5,  1'b1, 1'b1, 4'd5,  1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd5,  1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 4'd9,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 4'd9,  1'b1, 1'b1, 4'd9,  1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 4'd7,  1'b1, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd7,  1'b1, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[24] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd7,  1'b1, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd7,  1'b1, 1'b1};
        vecs[26] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd8,  1'b1, 1'b1};
        vecs[27] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd8,  1'b1, 1'b1};
        vecs[28] = '{1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 4'd3,  1'b1, 1'b1};
        vecs[29] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd3,  1'b1, 1'b1};
        vecs[30] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[31] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0};
        vecs[32] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[33] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b1};

        reset = 1'b1;
        bus.CLR = 1'b0;
        bus.LOAD_n = 1'b1;
        bus.D = 4'd0;
        bus.UP = 1'b1;
        bus.DOWN = 1'b1;
        loBus.CLR = 1'b0;
        loBus.LOAD_n = 1'b1;
        loBus.D = 4'd15;
        loBus.UP = 1'b1;
        loBus.DOWN = 1'b1;
        hiBus.CLR = 1'b0;
        hiBus.LOAD_n = 1'b1;
        hiBus.D = 4'd3;
        tick();
        tick();
        chkOut("reset", 4'd0, 1'b1, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < 34; i++) begin
            bus.CLR = vecs[i].clr;
            bus.LOAD_n = vecs[i].loadN;
            bus.D = vecs[i].d;
            bus.UP = vecs[i].up;
            bus.DOWN = vecs[i].down;
            tick();
            chkOut($sformatf("vec%0d", i), vecs[i].q, vecs[i].coN, vecs[i].boN);
        end

        // reset beats a pending load
        bus.LOAD_n = 1'b0;
        bus.D = 4'd9;
        reset = 1'b1;
        tick();
        chkOut("resetOverLoad", 4'd0, 1'b1, 1'b1);
        // reset taken while UP is low: the following rising UP still counts
        bus.LOAD_n = 1'b1;
        bus.UP = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chkOut("midPulseLow", 4'd0, 1'b1, 1'b1);
        bus.UP = 1'b1;
        tick();
        chkOut("midPulseRise", 4'd1, 1'b1, 1'b1);

        loBus.LOAD_n = 1'b0;
        hiBus.LOAD_n = 1'b0;
        tick();
        loBus.LOAD_n = 1'b1;
        hiBus.LOAD_n = 1'b1;
        chk("casLoadLo", loBus.Q, 4'd15);
        chk("casLoadHi", hiBus.Q, 4'd3);
        loBus.UP = 1'b0;
        tick();
        chk("casCarryLow", {3'b0, loBus.CO_n}, 4'd0);
        loBus.UP = 1'b1;
        tick();
        chk("casWrapLo", loBus.Q, 4'd0);
        chk("casWrapHiBefore", hiBus.Q, 4'd3);
        tick();
        chk("casWrapHiAfter", hiBus.Q, 4'd4);
        for (int i = 1; i < 256; i++) loPulse();
        tick();
        tick();
        chk("cas256Lo", loBus.Q, 4'd15);
        chk("cas256Hi", hiBus.Q, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
